// File: rtl/matmul_pkg.sv
// Shared constants and state types for the matrix multiplier complex.
// Used by the operand loader, the multiplier and the readout block.
package matmul_pkg;

  localparam int DATA_W    = 4;
  localparam int N_ELEM    = 18;
  localparam int N_COMPUTE = 9;
  localparam int RES_W     = 10;
  localparam int CNT_W     = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_SETUP,
    ST_LD_HI,
    ST_LD_LO,
    ST_CMP_HI,
    ST_CMP_LO,
    ST_WAIT_DONE,
    ST_DONE
  } ld_state_e;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_HI,
    PG_LO
  } pg_phase_e;

endpackage

// File: rtl/matmul_operand_loader_ic_pulse_gen.sv
// Strobe shaper: go starts a PULSE_W-high / GAP_W-low ic pulse.
// Ports: clk, rst (sync, high), go in; ic (flop), hi_end, fin out.
module ic_pulse_gen
  import matmul_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic ic,
  output logic hi_end,
  output logic fin
);

  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(MAXW + 1);

  pg_phase_e       phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ic_q, ic_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    hi_end  = (phase_q == PG_HI) && (cnt_q == '0);
    fin     = (phase_q == PG_LO) && (cnt_q == '0);
    unique case (phase_q)
      PG_IDLE: begin
        if (go) begin
          phase_d = PG_HI;
          cnt_d   = CW'(PULSE_W - 1);
        end
      end
      PG_HI: begin
        if (cnt_q == '0) begin
          phase_d = PG_LO;
          cnt_d   = CW'(GAP_W - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PG_LO: begin
        // go on the last gap cycle chains the next pulse back-to-back
        if (cnt_q == '0) begin
          if (go) begin
            phase_d = PG_HI;
            cnt_d   = CW'(PULSE_W - 1);
          end else begin
            phase_d = PG_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: phase_d = PG_IDLE;
    endcase
    // ic is a registered copy of the high phase: glitch-free by construction
    ic_d = (phase_q == PG_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PG_IDLE;
      cnt_q   <= '0;
      ic_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ic_q    <= ic_d;
    end
  end

  assign ic = ic_q;

endmodule

// File: rtl/matmul_operand_loader.sv
// Streams 18 operands onto the multiplier i/ic port, then 9 compute
// strobes, then waits for mm_done. Ports: start/in_* in, i/ic/en/... out.
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int PULSE_W      = 1,
  parameter int GAP_W        = 1,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              mr,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mm_done,
  output logic [DATA_W-1:0] i,
  output logic              ic,
  output logic              en,
  output logic              mm_clr,
  output logic              busy,
  output logic              seq_done,
  output logic              err
);

  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  ld_state_e          state_q, state_d;
  logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [CNT_W-1:0]   cmp_cnt_q, cmp_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0]  i_q, i_d;
  logic               in_ready_q, in_ready_d;
  logic               en_q, en_d;
  logic               mm_clr_q, mm_clr_d;
  logic               busy_q, busy_d;
  logic               seq_done_q, seq_done_d;
  logic               err_q, err_d;
  logic               go;
  logic               hi_end;
  logic               fin;
  logic               hs;

  ic_pulse_gen #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W)
  ) u_pg (
    .clk    (clk),
    .rst    (mr),
    .go     (go),
    .ic     (ic),
    .hi_end (hi_end),
    .fin    (fin)
  );

  assign hs = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    cmp_cnt_d  = cmp_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    i_d        = i_q;
    en_d       = en_q;
    mm_clr_d   = 1'b0;
    busy_d     = busy_q;
    seq_done_d = seq_done_q;
    err_d      = err_q;
    go         = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD_WAIT;
          mm_clr_d   = 1'b1;
          en_d       = 1'b1;
          busy_d     = 1'b1;
          seq_done_d = 1'b0;
          err_d      = 1'b0;
          elem_cnt_d = '0;
          cmp_cnt_d  = '0;
          tmo_cnt_d  = '0;
        end
      end
      ST_LOAD_WAIT: begin
        if (hs) begin
          i_d     = in_data;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        go      = 1'b1;
        state_d = ST_LD_HI;
      end
      ST_LD_HI: begin
        if (hi_end) state_d = ST_LD_LO;
      end
      ST_LD_LO: begin
        if (fin) begin
          elem_cnt_d = elem_cnt_q + CNT_W'(1);
          if (elem_cnt_q == CNT_W'(N_ELEM - 1)) begin
            state_d = ST_CMP_HI;
            go      = 1'b1;
          end else begin
            state_d = ST_LOAD_WAIT;
          end
        end
      end
      ST_CMP_HI: begin
        if (hi_end) state_d = ST_CMP_LO;
      end
      ST_CMP_LO: begin
        if (fin) begin
          cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
          if (cmp_cnt_q == CNT_W'(N_COMPUTE - 1)) begin
            state_d   = ST_WAIT_DONE;
            tmo_cnt_d = '0;
          end else begin
            state_d = ST_CMP_HI;
            go      = 1'b1;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (mm_done) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          seq_done_d = 1'b1;
          err_d      = 1'b0;
        end else if (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1)) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          seq_done_d = 1'b1;
          err_d      = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_LOAD_WAIT);
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      state_q    <= ST_IDLE;
      elem_cnt_q <= '0;
      cmp_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      i_q        <= '0;
      in_ready_q <= 1'b0;
      en_q       <= 1'b0;
      mm_clr_q   <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      cmp_cnt_q  <= cmp_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      i_q        <= i_d;
      in_ready_q <= in_ready_d;
      en_q       <= en_d;
      mm_clr_q   <= mm_clr_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
    end
  end

  assign i        = i_q;
  assign in_ready = in_ready_q;
  assign en       = en_q;
  assign mm_clr   = mm_clr_q;
  assign busy     = busy_q;
  assign seq_done = seq_done_q;
  assign err      = err_q;

endmodule
